// File: rtl/br_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit counters and a return-address stack.
// Lookup is combinational on lk_pc; training happens at resolve time from the execute stage.
module br_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lk_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [1:0]      upd_type,
  input  logic            upd_call,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            inv
);

  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int TAG_W   = XLEN - IDX_W - 2;
  localparam bit HAS_RAS = (RAS_DEPTH > 0);

  typedef enum logic [1:0] {
    T_BR  = 2'b00,
    T_JMP = 2'b01,
    T_RET = 2'b10,
    T_RSV = 2'b11
  } br_type_e;

  logic            ent_valid [ENTRIES];
  logic [TAG_W-1:0] ent_tag  [ENTRIES];
  logic [XLEN-3:0] ent_tgt   [ENTRIES];
  br_type_e        ent_type  [ENTRIES];
  logic [1:0]      ent_ctr   [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit;
  logic [XLEN-1:0]  ras_top;
  logic             ras_nonempty;
  logic [XLEN-1:0]  seq_pc;
  logic             unused_bits;

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
  assign lk_hit  = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
  assign upd_hit = ent_valid[upd_idx] && (ent_tag[upd_idx] == upd_tag);
  assign seq_pc  = {lk_pc[XLEN-1:2] + (XLEN-2)'(1), 2'b00};
  assign unused_bits = ^{lk_pc[1:0], upd_target[1:0], ras_top[1:0]};

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = seq_pc;
    if (lk_hit) begin
      unique case (ent_type[lk_idx])
        T_BR:    pred_taken = ent_ctr[lk_idx][1];
        T_JMP:   pred_taken = 1'b1;
        T_RET:   pred_taken = ras_nonempty || !HAS_RAS;
        default: pred_taken = 1'b0;
      endcase
    end
    if (pred_taken) begin
      if (ent_type[lk_idx] == T_RET && HAS_RAS)
        pred_target = {ras_top[XLEN-1:2], 2'b00};
      else
        pred_target = {ent_tgt[lk_idx], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ent_valid[i] <= 1'b0;
        ent_tag[i]   <= '0;
        ent_tgt[i]   <= '0;
        ent_type[i]  <= T_BR;
        ent_ctr[i]   <= 2'b01;
      end
    end else if (inv) begin
      for (int unsigned i = 0; i < ENTRIES; i++)
        ent_valid[i] <= 1'b0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ent_tgt[upd_idx]  <= upd_target[XLEN-1:2];
        ent_type[upd_idx] <= br_type_e'(upd_type);
        if (upd_type == T_BR) begin
          if (upd_taken)
            ent_ctr[upd_idx] <= (ent_ctr[upd_idx] == 2'b11) ? 2'b11 : ent_ctr[upd_idx] + 2'b01;
          else
            ent_ctr[upd_idx] <= (ent_ctr[upd_idx] == 2'b00) ? 2'b00 : ent_ctr[upd_idx] - 2'b01;
        end else begin
          ent_ctr[upd_idx] <= 2'b11;
        end
      end else if (upd_taken) begin
        ent_valid[upd_idx] <= 1'b1;
        ent_tag[upd_idx]   <= upd_tag;
        ent_tgt[upd_idx]   <= upd_target[XLEN-1:2];
        ent_type[upd_idx]  <= br_type_e'(upd_type);
        ent_ctr[upd_idx]   <= (upd_type == T_BR) ? 2'b10 : 2'b11;
      end
    end
  end

  generate
    if (HAS_RAS) begin : g_ras
      localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
      localparam int CNT_W = $clog2(RAS_DEPTH + 1);

      logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
      logic [PTR_W-1:0] ptr, ptr_nxt, top_slot, ptr_inc, wr_slot;
      logic [CNT_W-1:0] cnt, cnt_nxt;
      logic             do_pop, do_push;

      // ptr is the next free slot; the top of stack lives just below it (circular).
      assign top_slot = (ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr - PTR_W'(1);
      assign ptr_inc  = (ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
      assign do_pop   = upd_valid && (upd_type == T_RET) && (cnt != '0);
      assign do_push  = upd_valid && upd_call;
      // Pop-then-push collapses into an in-place overwrite of the top slot.
      assign wr_slot  = do_pop ? top_slot : ptr;

      always_comb begin
        ptr_nxt = ptr;
        cnt_nxt = cnt;
        if (do_push && !do_pop) begin
          ptr_nxt = ptr_inc;
          cnt_nxt = (cnt == CNT_W'(RAS_DEPTH)) ? cnt : cnt + CNT_W'(1);
        end else if (do_pop && !do_push) begin
          ptr_nxt = top_slot;
          cnt_nxt = cnt - CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ptr <= '0;
          cnt <= '0;
        end else if (inv) begin
          cnt <= '0;
        end else begin
          ptr <= ptr_nxt;
          cnt <= cnt_nxt;
        end
      end

      always_ff @(posedge clk) begin
        if (do_push && !inv)
          ras_mem[wr_slot] <= upd_pc + XLEN'(4);
      end

      assign ras_top      = ras_mem[top_slot];
      assign ras_nonempty = (cnt != '0);
    end else begin : g_no_ras
      assign ras_top      = '0;
      assign ras_nonempty = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_br_predictor.sv
// Randomised and directed bench for br_predictor against a table/queue reference model.
module tb_br_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lk_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_type;
  logic        upd_call;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        inv;

  int n_checks = 0;
  int n_errors = 0;

  br_predictor #(.XLEN(32), .ENTRIES(16), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .lk_pc(lk_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_type(upd_type), .upd_call(upd_call),
    .upd_taken(upd_taken), .upd_target(upd_target), .inv(inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit [25:0] tag;
    bit [31:0] tgt;
    bit [1:0]  ty;
    int        ctr;
  } ent_t;

  ent_t        m_btb [16];
  bit   [31:0] m_ras [$];
  logic        obs_taken;
  logic [31:0] obs_tgt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_btb[i].v   = 0;
      m_btb[i].ctr = 1;
    end
    m_ras.delete();
  endfunction

  function automatic void model_pred(input bit [31:0] pc, output bit t, output bit [31:0] tg);
    int  i   = int'(pc[5:2]);
    bit  hit = m_btb[i].v && (m_btb[i].tag == pc[31:6]);
    t  = hit && ((m_btb[i].ty == 2'd1) || (m_btb[i].ty == 2'd0 && m_btb[i].ctr >= 2) ||
                 (m_btb[i].ty == 2'd2 && m_ras.size() > 0));
    tg = pc + 32'd4;
    if (t) tg = (m_btb[i].ty == 2'd2) ? m_ras[$] : m_btb[i].tgt;
  endfunction

  function automatic void model_update(input bit uv, input bit [31:0] pc, input bit [1:0] ty,
                                       input bit call, input bit tk, input bit [31:0] tg, input bit iv);
    int i   = int'(pc[5:2]);
    bit hit = m_btb[i].v && (m_btb[i].tag == pc[31:6]);
    if (iv) begin
      for (int k = 0; k < 16; k++) m_btb[k].v = 0;
      m_ras.delete();
      return;
    end
    if (!uv) return;
    if (hit) begin
      m_btb[i].tgt = tg & ~32'd3;
      m_btb[i].ty  = ty;
      if (ty == 2'd0) m_btb[i].ctr = tk ? ((m_btb[i].ctr == 3) ? 3 : m_btb[i].ctr + 1)
                                        : ((m_btb[i].ctr == 0) ? 0 : m_btb[i].ctr - 1);
      else m_btb[i].ctr = 3;
    end else if (tk) begin
      m_btb[i].v   = 1;
      m_btb[i].tag = pc[31:6];
      m_btb[i].tgt = tg & ~32'd3;
      m_btb[i].ty  = ty;
      m_btb[i].ctr = (ty == 2'd0) ? 2 : 3;
    end
    if (ty == 2'd2 && m_ras.size() > 0) void'(m_ras.pop_back());
    if (call) begin
      m_ras.push_back(pc + 32'd4);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
  endfunction

  task automatic step(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                      input logic [1:0] ut, input logic uc, input logic utk,
                      input logic [31:0] utg, input logic iv);
    bit        et;
    bit [31:0] eg;
    @(negedge clk);
    lk_pc = lk; upd_valid = uv; upd_pc = upc; upd_type = ut;
    upd_call = uc; upd_taken = utk; upd_target = utg; inv = iv;
    #1;
    model_pred(lk, et, eg);
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, et});
    chk("pred_target", pred_target, eg);
    obs_taken = pred_taken;
    obs_tgt   = pred_target;
    model_update(uv, upc, ut, uc, utk, utg, iv);
  endtask

  task automatic look(input logic [31:0] lk);
    step(lk, 1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; lk_pc = 32'h100; upd_valid = 0; upd_pc = 0; upd_type = 0;
    upd_call = 0; upd_taken = 0; upd_target = 0; inv = 0;
    model_reset();

    // reset state across every index, plus fall-through wrap
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      lk_pc = 32'h100 + 32'(i * 4);
      #1;
      chk("rst_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_target", pred_target, 32'h104 + 32'(i * 4));
    end
    @(negedge clk); lk_pc = 32'hFFFF_FFFC; #1;
    chk("wrap_target", pred_target, 32'h0);
    rst = 1'b0;

    // counter training at 0x40
    step(32'h40, 1, 32'h40, 2'd0, 0, 1, 32'h80, 0);
    step(32'h40, 1, 32'h40, 2'd0, 0, 0, 32'h80, 0);
    chk("ctr10_taken", {31'd0, obs_taken}, 32'd1);
    chk("ctr10_target", obs_tgt, 32'h80);
    step(32'h40, 1, 32'h40, 2'd0, 0, 0, 32'h80, 0);
    step(32'h40, 1, 32'h40, 2'd0, 0, 1, 32'h80, 0);
    chk("ctr00_target", obs_tgt, 32'h44);
    step(32'h40, 1, 32'h40, 2'd0, 0, 1, 32'h80, 0);
    step(32'h40, 1, 32'h40, 2'd0, 0, 1, 32'h80, 0);
    step(32'h40, 1, 32'h40, 2'd0, 0, 0, 32'h80, 0);
    chk("ctr11_target", obs_tgt, 32'h80);
    look(32'h40);
    chk("ctr_sat_target", obs_tgt, 32'h80);

    // aliasing: 0x80 shares index 0 with 0x40
    step(32'h80, 1, 32'h80, 2'd1, 0, 1, 32'h500, 0);
    look(32'h40);
    chk("alias_old_miss", obs_tgt, 32'h44);
    look(32'h80);
    chk("alias_new_hit", obs_tgt, 32'h500);

    // RAS overflow and drain
    for (int i = 1; i <= 5; i++)
      step(32'h0, 1, 32'(i * 16), 2'd1, 1, 1, 32'h1000, 0);
    step(32'h200, 1, 32'h200, 2'd2, 0, 1, 32'h998, 0);
    step(32'h200, 1, 32'h200, 2'd2, 0, 1, 32'h998, 0);
    chk("ras_pop1", obs_tgt, 32'h44);
    step(32'h200, 1, 32'h200, 2'd2, 0, 1, 32'h998, 0);
    chk("ras_pop2", obs_tgt, 32'h34);
    step(32'h200, 1, 32'h200, 2'd2, 0, 1, 32'h998, 0);
    chk("ras_pop3", obs_tgt, 32'h24);
    step(32'h200, 1, 32'h200, 2'd2, 0, 1, 32'h998, 0);
    chk("ras_empty_taken", {31'd0, obs_taken}, 32'd0);
    chk("ras_empty_target", obs_tgt, 32'h204);

    // same-cycle lookup/update, then invalidate racing an update
    step(32'h0, 1, 32'h40, 2'd0, 0, 1, 32'h80, 0);
    step(32'h40, 1, 32'h40, 2'd1, 0, 1, 32'h300, 0);
    chk("same_cyc_old", obs_tgt, 32'h80);
    look(32'h40);
    chk("same_cyc_new", obs_tgt, 32'h300);
    step(32'h40, 1, 32'h80, 2'd1, 0, 1, 32'h600, 1);
    look(32'h40);
    chk("inv_miss40", obs_tgt, 32'h44);
    look(32'h80);
    chk("inv_miss80", obs_tgt, 32'h84);

    // asynchronous reset mid-cycle while an update is pending
    step(32'h0, 1, 32'h40, 2'd1, 0, 1, 32'h300, 0);
    step(32'h40, 1, 32'h80, 2'd1, 1, 1, 32'h700, 0);
    chk("pre_rst_taken", {31'd0, obs_taken}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_taken", {31'd0, pred_taken}, 32'd0);
    chk("async_rst_target", pred_target, 32'h44);
    model_reset();
    @(negedge clk);
    upd_valid = 0;
    rst = 1'b0;
    look(32'h40);
    look(32'h80);

    // randomised traffic over a few tags per index
    for (int n = 0; n < 600; n++) begin
      logic [31:0] lk, upc, tg;
      logic [1:0]  ty;
      logic        uv, tk, cl, iv;
      lk  = 32'h1000 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 15)) << 2);
      upc = 32'h1000 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 15)) << 2);
      tg  = $urandom;
      ty  = 2'($urandom_range(0, 2));
      uv  = ($urandom_range(0, 9) < 6);
      tk  = (ty != 2'd0) ? 1'b1 : 1'($urandom_range(0, 1));
      cl  = (ty != 2'd0) && ($urandom_range(0, 3) == 0);
      iv  = ($urandom_range(0, 49) == 0);
      step(lk, uv, upc, ty, cl, tk, tg, iv);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
